keypad_scan: RTL and testbench

//  Input-side counterpart of the multiplexed 7-seg display driver: scans a 4x4 hex matrix keypad
//  by driving one column low at a time (1 ms per column) and reading the rows. It debounces and

---
 rtl/keypad_scan.sv | 171 +++++++++++++++++
 tb/tb_keypad_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, frame-level debounce,
// single-key validation and a 4-digit hex entry shift register.
module keypad_scan #(
   parameter int Fclk       = 50000000,
   parameter int F1kHz      = 1000,
   parameter int DEB_FRAMES = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        clr,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic [15:0] entry
);

   localparam int PER = Fclk / F1kHz;
   localparam int TW  = $clog2(PER + 1);
   localparam int DW  = $clog2(DEB_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;

   logic [TW-1:0] tcnt;
   logic          ce;
   logic [3:0]    row_m;
   logic [3:0]    row_s;
   logic [1:0]    ci;
   logic [1:0]    acc_n;
   logic [3:0]    acc_code;

   logic [2:0]    s_n;
   logic [1:0]    s_r;
   logic [1:0]    base_n;
   logic [2:0]    sum;
   logic [1:0]    f_n;
   logic [3:0]    f_code;
   logic          frame_done;
   logic          one;
   logic          none;

   state_t        state;
   logic [DW-1:0] dcnt;
   logic [DW-1:0] dnext;
   logic [3:0]    cand;

   assign ce = (tcnt == TW'(PER));

   // Timebase, row synchroniser and column rotation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt     <= '0;
         row_m    <= 4'hF;
         row_s    <= 4'hF;
         ci       <= 2'd0;
         col      <= 4'b1110;
         acc_n    <= 2'd0;
         acc_code <= 4'd0;
      end else begin
         row_m <= row;
         row_s <= row_m;
         if (ce) begin
            tcnt     <= TW'(1);
            ci       <= ci + 2'd1;
            col      <= {col[2:0], col[3]};
            acc_n    <= f_n;
            acc_code <= f_code;
         end else begin
            tcnt <= tcnt + TW'(1);
         end
      end
   end

   // Low rows in the current sample; the frame tally saturates at 2.
   always_comb begin
      s_n = 3'd0;
      s_r = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_s[r]) begin
            s_n = s_n + 3'd1;
            s_r = 2'(r);
         end
      end
      base_n = (ci == 2'd0) ? 2'd0 : acc_n;
      sum    = {1'b0, base_n} + s_n;
      f_n    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      f_code = (s_n == 3'd1) ? {s_r, ci} : acc_code;
   end

   assign frame_done = ce && (ci == 2'd3);
   assign one        = (f_n == 2'd1);
   assign none       = (f_n == 2'd0);
   assign dnext      = dcnt + DW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dcnt      <= '0;
         cand      <= 4'd0;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         key_held  <= 1'b0;
         entry     <= 16'h0000;
      end else begin
         key_valid <= 1'b0;
         if (clr) entry <= 16'h0000;
         if (frame_done) begin
            unique case (state)
               IDLE: begin
                  if (one) begin
                     cand <= f_code;
                     if (DEB_FRAMES == 1) begin
                        state     <= HELD;
                        key_held  <= 1'b1;
                        key_valid <= 1'b1;
                        key_code  <= f_code;
                        entry     <= clr ? {12'h000, f_code}
                                         : {entry[11:0], f_code};
                     end else begin
                        state <= DEB;
                        dcnt  <= DW'(1);
                     end
                  end
               end
               DEB: begin
                  if (one && f_code == cand) begin
                     dcnt <= dnext;
                     if (dnext == DW'(DEB_FRAMES)) begin
                        state     <= HELD;
                        key_held  <= 1'b1;
                        key_valid <= 1'b1;
                        key_code  <= cand;
                        entry     <= clr ? {12'h000, cand}
                                         : {entry[11:0], cand};
                     end
                  end else begin
                     state <= IDLE;
                     dcnt  <= '0;
                  end
               end
               HELD: begin
                  if (none) begin
                     if (DEB_FRAMES == 1) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                        dcnt     <= '0;
                     end else begin
                        state <= REL;
                        dcnt  <= DW'(1);
                     end
                  end
               end
               REL: begin
                  if (none) begin
                     dcnt <= dnext;
                     if (dnext == DW'(DEB_FRAMES)) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                        dcnt     <= '0;
                     end
                  end else begin
                     state <= HELD;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model driven by col, a
// frame-level reference model, per-cycle compare and directed scenarios.
module tb_keypad_scan;

   localparam int FCLK  = 8000;
   localparam int F1K   = 1000;
   localparam int DEB   = 3;
   localparam int PER   = FCLK / F1K;
   localparam int FRAME = 4 * PER;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] entry;
   logic [15:0] keys;

   int  passed = 0;
   int  total  = 0;
   int  strobes = 0;
   bit  chk_on = 0;

   keypad_scan #(.Fclk(FCLK), .F1kHz(F1K), .DEB_FRAMES(DEB)) dut (
      .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clr(clr),
      .key_code(key_code), .key_valid(key_valid),
      .key_held(key_held), .entry(entry)
   );

   always #5 clk = ~clk;

   // Physical matrix: a pressed key pulls its row low while its column is low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   // Reference model: cycle n since reset, sample at every PER-th cycle.
   int          n;
   logic [3:0]  rs1, rs2, samp;
   int          lows, fcode, st, dc, cand, c;
   bit          acc;
   logic        m_valid, m_held;
   logic [3:0]  m_code, m_col;
   logic [15:0] m_entry;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0; rs1 = 4'hF; rs2 = 4'hF; lows = 0; fcode = 0;
         st = 0; dc = 0; cand = 0;
         m_valid = 0; m_held = 0; m_code = 0; m_entry = 0;
         m_col = 4'b1110;
      end else begin
         samp = rs2; rs2 = rs1; rs1 = row;
         acc = 0;
         if (n > 0 && n % PER == 0) begin
            c = ((n - 1) / PER) % 4;
            if (c == 0) lows = 0;
            for (int r = 0; r < 4; r++)
               if (!samp[r]) begin lows++; fcode = r * 4 + c; end
            if (c == 3) begin
               case (st)
                  0: if (lows == 1) begin
                        cand = fcode;
                        if (DEB == 1) begin st = 2; acc = 1; end
                        else begin st = 1; dc = 1; end
                     end
                  1: if (lows == 1 && fcode == cand) begin
                        dc++;
                        if (dc == DEB) begin st = 2; acc = 1; end
                     end else st = 0;
                  2: if (lows == 0) begin
                        if (DEB == 1) st = 0;
                        else begin st = 3; dc = 1; end
                     end
                  3: if (lows == 0) begin
                        dc++;
                        if (dc == DEB) st = 0;
                     end else st = 2;
                  default: ;
               endcase
               m_held = (st >= 2);
            end
         end
         m_valid = acc;
         if (acc) m_code = 4'(cand);
         if (clr) m_entry = acc ? {12'h000, 4'(cand)} : 16'h0000;
         else if (acc) m_entry = {m_entry[11:0], 4'(cand)};
         n++;
         m_col = ~(4'b0001 << (((n - 1) / PER) % 4));
      end
   end

   task automatic check(input string name, input logic [15:0] got,
                        input logic [15:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h, want %h", name, got, want);
   endtask

   always @(negedge clk) begin
      if (key_valid === 1'b1) strobes++;
      if (chk_on) begin
         check("col", 16'(col), 16'(m_col));
         check("key_valid", 16'(key_valid), 16'(m_valid));
         check("key_code", 16'(key_code), 16'(m_code));
         check("key_held", 16'(key_held), 16'(m_held));
         check("entry", entry, m_entry);
      end
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
      #1;
   endtask

   task automatic align();
      int b;
      b = 0;
      do begin cyc(1); b++; end while (n % FRAME != 1 && b < 2 * FRAME);
      check("align_timeout", 16'(n % FRAME), 16'd1);
   endtask

   int s0;
   logic [3:0] seq [4];
   bit got;

   initial begin
      rst_n = 1'b0; clr = 1'b0; keys = 16'h0000;
      seq[0] = 4'b1101; seq[1] = 4'b1011;
      seq[2] = 4'b0111; seq[3] = 4'b1110;
      cyc(3);
      chk_on = 1;
      check("rst_col", 16'(col), 16'h000E);
      check("rst_entry", entry, 16'h0000);
      check("rst_held", 16'(key_held), 16'h0000);
      rst_n = 1'b1;

      // Idle scan: first column gets one extra cycle out of reset.
      cyc(9);
      for (int j = 0; j < 4; j++) begin
         check("scan_col", 16'(col), 16'(seq[j]));
         cyc(8);
      end
      check("idle_strobes", 16'(strobes), 16'd0);

      // Single clean press of key 6 (r1,c2).
      align();
      s0 = strobes;
      keys = 16'h0040;
      cyc(6 * FRAME);
      check("k6_strobes", 16'(strobes - s0), 16'd1);
      check("k6_code", 16'(key_code), 16'd6);
      check("k6_entry", entry, 16'h0006);
      check("k6_held", 16'(key_held), 16'd1);
      keys = 16'h0000;
      cyc(2 * FRAME);
      check("k6_rel2", 16'(key_held), 16'd1);
      cyc(FRAME);
      check("k6_rel3", 16'(key_held), 16'd0);

      // Bounce: 2 press, 1 open, then 3 press.
      s0 = strobes;
      keys = 16'h0040; cyc(2 * FRAME);
      keys = 16'h0000; cyc(FRAME);
      keys = 16'h0040; cyc(2 * FRAME);
      check("bounce_early", 16'(strobes - s0), 16'd0);
      cyc(FRAME);
      check("bounce_one", 16'(strobes - s0), 16'd1);
      keys = 16'h0000; cyc(4 * FRAME);

      // Two keys at once never count; an added key while held is ignored.
      s0 = strobes;
      keys = 16'h8001; cyc(5 * FRAME);
      check("multi_none", 16'(strobes - s0), 16'd0);
      check("multi_held", 16'(key_held), 16'd0);
      keys = 16'h0000; cyc(FRAME);
      keys = 16'h0020; cyc(4 * FRAME);
      s0 = strobes;
      keys = 16'h0220; cyc(3 * FRAME);
      check("add_key", 16'(strobes - s0), 16'd0);
      check("add_held", 16'(key_held), 16'd1);
      check("add_code", 16'(key_code), 16'd5);
      keys = 16'h0000; cyc(4 * FRAME);
      check("entry_665", entry, 16'h0665);
      check("idle_held", 16'(key_held), 16'd0);

      // Digits 1..5, then clr overlapping the accept of 7.
      for (int k = 1; k <= 5; k++) begin
         keys = 16'(1) << k; cyc(4 * FRAME);
         keys = 16'h0000;    cyc(4 * FRAME);
      end
      check("entry_2345", entry, 16'h2345);
      keys = 16'h0080;
      cyc(2 * FRAME);
      clr = 1'b1;
      got = 0;
      for (int w = 0; w < 2 * FRAME && !got; w++) begin
         cyc(1);
         if (key_valid === 1'b1) got = 1;
      end
      clr = 1'b0;
      check("clr_strobe_seen", 16'(got), 16'd1);
      cyc(1);
      check("clr_entry", entry, 16'h0007);
      check("clr_code", 16'(key_code), 16'd7);
      keys = 16'h0000; cyc(4 * FRAME);

      // Asynchronous reset while a key is held.
      keys = 16'h0020; cyc(4 * FRAME);
      check("pre_rst_held", 16'(key_held), 16'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_col", 16'(col), 16'h000E);
      check("arst_entry", entry, 16'h0000);
      check("arst_code", 16'(key_code), 16'd0);
      check("arst_held", 16'(key_held), 16'd0);
      check("arst_valid", 16'(key_valid), 16'd0);
      cyc(3);
      rst_n = 1'b1;
      s0 = strobes;
      cyc(90);
      check("post_rst_early", 16'(strobes - s0), 16'd0);
      cyc(12);
      check("post_rst_one", 16'(strobes - s0), 16'd1);
      check("post_rst_entry", entry, 16'h0005);
      keys = 16'h0000; cyc(4 * FRAME);

      chk_on = 0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
